// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton
// Registered, flow-controlled 1-to-N demultiplexer. Each accepted input word
// is written into the one-entry holding register of the channel chosen by
// Selector and becomes visible one cycle later. Each channel has its own
// valid/ready pair, so a stalled channel never blocks words for other
// channels. Words with an out-of-range Selector are consumed and discarded,
// and are recorded in a sticky error flag and a saturating drop counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   Demux_Input  data word to route
//   Selector     destination channel index, sampled with Demux_Input
//   in_valid     Demux_Input/Selector are valid
//   in_ready     the presented word can be accepted this cycle
//   Dataout      flattened channel data, channel k at [k*DATA_LENGTH +: DATA_LENGTH]
//   out_valid    bit k: channel k holds a word
//   out_ready    bit k: consumer of channel k takes the word this cycle
//   sel_error    sticky flag, set when an out-of-range Selector is accepted
//   drop_count   saturating count of discarded out-of-range words
module demux_stream_1ton #(
    parameter int DATA_LENGTH = 32,
    parameter int NUM_OUTPUTS = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int ZERO_IDLE   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_LENGTH-1:0]             Demux_Input,
    input  logic [SEL_WIDTH-1:0]               Selector,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [DATA_LENGTH*NUM_OUTPUTS-1:0] Dataout,
    output logic [NUM_OUTPUTS-1:0]             out_valid,
    input  logic [NUM_OUTPUTS-1:0]             out_ready,
    output logic                               sel_error,
    output logic [15:0]                        drop_count
);

    // When every Selector code names a real channel there is nothing to drop.
    localparam bit                 SEL_FULL  = (NUM_OUTPUTS == (2 ** SEL_WIDTH));
    localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH + 1)'(NUM_OUTPUTS);

    logic [NUM_OUTPUTS-1:0] full;
    logic [DATA_LENGTH-1:0] data_q [NUM_OUTPUTS];
    logic                   sel_ok;
    logic                   sel_free;
    logic                   accept;
    logic [NUM_OUTPUTS-1:0] fill;

    // Readiness looks only at the addressed channel. A channel counts as free
    // when it is empty or is being drained this cycle, which lets a channel
    // stream one word per cycle. The channel is found by comparison rather
    // than by indexing so an out-of-range Selector never indexes past the
    // array.
    always_comb begin
        sel_ok   = SEL_FULL ? 1'b1 : ({1'b0, Selector} < SEL_LIMIT);
        sel_free = 1'b0;
        fill     = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (Selector == SEL_WIDTH'(k)) begin
                sel_free = !full[k] || out_ready[k];
            end
        end
        in_ready = !reset && (!sel_ok || sel_free);
        accept   = in_valid && in_ready;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            fill[k] = accept && sel_ok && (Selector == SEL_WIDTH'(k));
        end
    end

    // Channel holding registers. A refill takes priority over a drain so a
    // channel drained and refilled in the same cycle stays full with the new
    // word.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (fill[k]) begin
                    full[k]   <= 1'b1;
                    data_q[k] <= Demux_Input;
                end else if (out_ready[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = full;

    // With ZERO_IDLE the lanes of an empty channel read zero; otherwise each
    // lane shows whatever word it last held.
    genvar g;
    generate
        for (g = 0; g < NUM_OUTPUTS; g++) begin : g_lane
            if (ZERO_IDLE != 0) begin : g_zero
                assign Dataout[g*DATA_LENGTH +: DATA_LENGTH] = full[g] ? data_q[g] : '0;
            end else begin : g_hold
                assign Dataout[g*DATA_LENGTH +: DATA_LENGTH] = data_q[g];
            end
        end
    endgenerate

    // Out-of-range accounting. Only reset clears the flag and the counter;
    // the counter sticks at its maximum instead of wrapping.
    generate
        if (SEL_FULL) begin : g_no_err
            assign sel_error  = 1'b0;
            assign drop_count = '0;
        end else begin : g_err
            always_ff @(posedge clk) begin
                if (reset) begin
                    sel_error  <= 1'b0;
                    drop_count <= '0;
                end else if (accept && !sel_ok) begin
                    sel_error <= 1'b1;
                    if (drop_count != 16'hFFFF) begin
                        drop_count <= drop_count + 16'd1;
                    end
                end
            end
        end
    endgenerate

endmodule
